// File: rtl/wave_replay_rd_if.sv
`default_nettype none
// ============================================================================
//  Module  : wave_replay_rd_if
//  Purpose : Capture-FIFO read port plus DAC sample port of the replay reader.
//  Rev     : 1.0  initial release
// ============================================================================
interface wave_replay_rd_if #(
    parameter int DATA_W = 10
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] da_data;
    logic              da_valid;

    // master: the replay reader (pulls from the FIFO, pushes to the DAC)
    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output da_data,
        output da_valid
    );

    // slave: FIFO model / DAC driver side
    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  da_data,
        input  da_valid
    );
endinterface
`default_nettype wire

// File: rtl/wave_replay_rd.sv
`default_nettype none
// ============================================================================
//  Module  : wave_replay_rd
//  Purpose : Drains one period of captured samples into local RAM, then replays
//            them to the DAC through a 32-bit phase accumulator.
//  Rev     : 1.0  initial release
// ============================================================================
module wave_replay_rd #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 10,
    parameter int INC_MUL  = 86,
    parameter int LOAD_TO  = 65535,
    parameter int MID_CODE = 512
) (
    input  wire logic        clk_50m,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic [15:0] wave_freq,
    input  wire logic        freq_vaild,
    wave_replay_rd_if.master bus,
    output logic             busy,
    output logic             load_err
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam int                TO_W    = $clog2(LOAD_TO + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(LOAD_TO - 1);
    localparam logic [DATA_W-1:0] MID     = DATA_W'(MID_CODE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_rd_vld;
    logic [TO_W-1:0]   r_to_cnt;
    logic [31:0]       r_inc;
    logic [31:0]       r_acc;
    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_ram_q;
    logic              r_q_vld;
    logic [DATA_W-1:0] r_da_data;
    logic              r_da_valid;
    logic              r_busy;
    logic              r_load_err;

    logic              w_accept;
    logic              w_rd_room;
    logic              w_rd_en;
    logic              w_last_wr;
    logic              w_empty_wait;
    logic              w_timeout;
    logic              w_play_hold;
    logic [23:0]       w_inc24;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_accept     = start && freq_vaild && (wave_freq != 16'd0);
    // MSB of the issued-read counter set means all DEPTH reads are out
    assign w_rd_room    = ~r_rd_cnt[ADDR_W];
    assign w_last_wr    = r_rd_vld && (r_wr_cnt == {ADDR_W{1'b1}});
    assign w_empty_wait = bus.fifo_empty && w_rd_room;
    assign w_timeout    = w_empty_wait && (r_to_cnt == TO_LAST);
    // 65535 * 86 stays below 2^23, so 24 bits hold the increment exactly
    assign w_inc24      = 24'(wave_freq) * 24'(INC_MUL);
    assign w_rd_addr    = r_acc[31 -: ADDR_W];

    always_comb begin
        w_state_nx  = r_state;
        w_rd_en     = 1'b0;
        w_play_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rd_en = !bus.fifo_empty && w_rd_room;
                if (w_last_wr) begin
                    w_state_nx = S_PLAY;
                end else if (w_timeout) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_PLAY: begin
                if (start) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_play_hold = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_load_err <= 1'b0;
            r_inc      <= 32'd0;
            r_acc      <= 32'd0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_rd_vld   <= 1'b0;
            r_to_cnt   <= '0;
            r_q_vld    <= 1'b0;
            r_da_valid <= 1'b0;
            r_da_data  <= MID;
        end else begin
            r_state  <= w_state_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_rd_vld <= w_rd_en;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_inc      <= {8'd0, w_inc24};
                        r_load_err <= 1'b0;
                        r_rd_cnt   <= '0;
                        r_wr_cnt   <= '0;
                        r_to_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                    if (r_rd_vld) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                    if (w_empty_wait) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end else begin
                        r_to_cnt <= '0;
                    end
                    if (w_timeout) begin
                        r_load_err <= 1'b1;
                    end
                    if (w_last_wr) begin
                        r_acc <= 32'd0;
                    end
                end
                S_PLAY: begin
                    r_acc <= r_acc + r_inc;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase

            // two-stage output pipe: RAM read register, then DAC register
            r_q_vld    <= w_play_hold;
            r_da_valid <= r_q_vld && w_play_hold;
            r_da_data  <= (r_q_vld && w_play_hold) ? r_ram_q : MID;
        end
    end

    // Replay RAM: contents are don't-care after reset, so no reset here
    always_ff @(posedge clk_50m) begin
        if ((r_state == S_LOAD) && r_rd_vld) begin
            r_ram[r_wr_cnt] <= bus.fifo_rd_data;
        end
        r_ram_q <= r_ram[w_rd_addr];
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.da_data    = r_da_data;
    assign bus.da_valid   = r_da_valid;
    assign busy           = r_busy;
    assign load_err       = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_wave_replay_rd.sv
`default_nettype none
// ============================================================================
//  Module  : tb_wave_replay_rd
//  Purpose : Randomised bench for wave_replay_rd against a queue-based FIFO
//            and an arithmetic phase/address reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_wave_replay_rd;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 10;
    localparam int INC_MUL = 86;
    localparam int LOAD_TO = 50;
    localparam int MID     = 512;
    localparam int DEPTH   = 256;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] wave_freq;
    logic        freq_vaild;
    logic        busy;
    logic        load_err;

    wave_replay_rd_if #(.DATA_W(DATA_W)) bus ();

    wave_replay_rd #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INC_MUL (INC_MUL),
        .LOAD_TO (LOAD_TO),
        .MID_CODE(MID)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .start     (start),
        .wave_freq (wave_freq),
        .freq_vaild(freq_vaild),
        .bus       (bus),
        .busy      (busy),
        .load_err  (load_err)
    );

    always #10 clk_50m = ~clk_50m;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                ncyc     = 0;
    int                rd_count = 0;
    bit                pend     = 1'b0;
    bit                gap_en   = 1'b0;
    bit                gap      = 1'b0;
    logic [DATA_W-1:0] pend_word;
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_ram[DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    // One clock: FIFO model answers on the falling edge, read strobe sampled just after
    task automatic tick();
        @(negedge clk_50m);
        ncyc++;
        if (pend) bus.fifo_rd_data = pend_word;
        gap            = gap_en ? ~gap : 1'b0;
        bus.fifo_empty = (fq.size() == 0) || gap;
        #1;
        pend = bus.fifo_rd_en;
        if (pend) begin
            check("rd_while_empty", 32'(bus.fifo_empty), 32'd0);
            pend_word = (fq.size() > 0) ? fq.pop_front() : '0;
            if (rd_count < DEPTH) exp_ram[rd_count] = pend_word;
            rd_count++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            fq.push_back(ramp ? DATA_W'(i) : DATA_W'($urandom));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_da_valid"}, 32'(bus.da_valid), 32'd0);
        check({tag, "_da_data"}, 32'(bus.da_data), 32'(MID));
        check({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    endtask

    // Full session: start, DEPTH reads, then cycle-by-cycle replay versus the model
    task automatic load_and_play(input int unsigned freq, input int ncheck, input bit inj_start);
        int          guard;
        int          k;
        logic [31:0] inc;
        logic [31:0] ph;
        rd_count   = 0;
        wave_freq  = 16'(freq);
        freq_vaild = 1'b1;
        inc        = freq * INC_MUL;
        pulse_start();
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_err_clr", 32'(load_err), 32'd0);
        guard = 0;
        while (rd_count < DEPTH && guard < 5000) begin
            tick();
            guard++;
            start = inj_start && (guard == 20);
        end
        start = 1'b0;
        check("load_reads", 32'(rd_count), 32'(DEPTH));
        if (rd_count != DEPTH) return;
        tick();
        tick();
        check("play_entry_busy", 32'(busy), 32'd1);
        check("play_entry_valid", 32'(bus.da_valid), 32'd0);
        tick();
        check("play_lat_valid", 32'(bus.da_valid), 32'd0);
        for (k = 0; k < ncheck; k++) begin
            tick();
            if (k == ncheck / 2) begin
                wave_freq  = 16'($urandom);
                freq_vaild = 1'b0;
            end
            ph = 32'(longint'(k) * longint'(inc));
            check("play_valid", 32'(bus.da_valid), 32'd1);
            check("play_data", 32'(bus.da_data), 32'(exp_ram[ph[31:24]]));
        end
        check("play_no_extra_rd", 32'(rd_count), 32'(DEPTH));
    endtask

    initial begin
        int guard;
        int empty_busy;
        rst            = 1'b1;
        start          = 1'b0;
        wave_freq      = 16'd0;
        freq_vaild     = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        repeat (3) tick();
        check_idle("rst");
        check("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // start ignored without a valid nonzero frequency
        fill(10, 1'b0);
        rd_count   = 0;
        wave_freq  = 16'd5000;
        freq_vaild = 1'b0;
        pulse_start();
        repeat (20) tick();
        check("novalid_reads", 32'(rd_count), 32'd0);
        check("novalid_busy", 32'(busy), 32'd0);
        freq_vaild = 1'b1;
        wave_freq  = 16'd0;
        pulse_start();
        repeat (20) tick();
        check("zerofreq_reads", 32'(rd_count), 32'd0);
        check("zerofreq_busy", 32'(busy), 32'd0);
        fq.delete();

        // short FIFO: LOAD_TO consecutive empty cycles abort the load
        fill(100, 1'b0);
        rd_count   = 0;
        wave_freq  = 16'($urandom_range(65535, 1));
        pulse_start();
        guard      = 0;
        empty_busy = 0;
        while (busy && guard < 1000) begin
            tick();
            guard++;
            if (busy && bus.fifo_empty) empty_busy++;
        end
        check("to_reads", 32'(rd_count), 32'd100);
        check("to_empty_cycles", 32'(empty_busy), 32'(LOAD_TO));
        check("to_load_err", 32'(load_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);

        // 5 kHz ramp over a full period, crossing the 2^32 accumulator wrap
        fill(DEPTH, 1'b1);
        load_and_play(5000, 10100, 1'b0);

        // stop from PLAY, FIFO refilled but not read while idle
        fill(300, 1'b0);
        pulse_start();
        check_idle("stop");
        rd_count = 0;
        repeat (10) tick();
        check("stop_no_reads", 32'(rd_count), 32'd0);

        // gappy FIFO, stray start during LOAD, random frequency
        gap_en = 1'b1;
        load_and_play($urandom_range(65535, 1), 3000, 1'b1);
        gap_en = 1'b0;
        check("fifo_left", 32'(fq.size()), 32'd44);

        // asynchronous reset mid-replay
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_err", 32'(load_err), 32'd0);
        pend = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        rd_count = 0;
        repeat (3) tick();
        check_idle("after_rst");
        check("after_rst_reads", 32'(rd_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
